tile_state_mgr: RTL and testbench
=================================

// Module: tile_state_mgr
// PURPOSE
//   Next-generation tile state store for the minesweeper core. Supports a rectangular
//   GRID_W x GRID_H board and holds the per-tile flagged and revealed bit-vectors.
//   Adds flag/reveal counters, a flag budget, mine-hit detection, reveal-all-mines on
//   loss, win detection and a game FSM. Sits between the cursor/input controller and
//   the flood-fill engine; its outputs drive the renderer and HUD.
// PARAMETERS
//   GRID_W      8                          board columns
//   GRID_H      8                          board rows
//   NUM_MINES   10                         mines on board; also the flag budget
//   TOTAL_TILES GRID_W*GRID_H              tile count (derived)
//   INDEX_BITS  $clog2(TOTAL_TILES)        tile index width (derived)
//   CNT_BITS    $clog2(TOTAL_TILES+1)      counter width (derived)
// PORTS
//   clk            in   1            system clock
//   rst            in   1            asynchronous, active-low reset
//   new_game       in   1            synchronous clear, one-cycle pulse
//   tile_index     in   INDEX_BITS   cursor tile, index = row*GRID_W + col
//   flag           in   1            toggle flag on tile_index, one-cycle pulse
//   reveal         in   1            reveal tile_index, one-cycle pulse
//   mine_map       in   TOTAL_TILES  1 = mine; must be stable while in PLAY
//   flood_update   in   TOTAL_TILES  reveal mask from flood-fill
//   flood_apply    in   1            flood_update valid this cycle
//   flagged        out  TOTAL_TILES  persistent flag state
//   revealed       out  TOTAL_TILES  persistent reveal state
//   flag_count     out  CNT_BITS     number of set flagged bits
//   revealed_count out  CNT_BITS     popcount(revealed), registered
//   game_state     out  2            0 IDLE, 1 PLAY, 2 WON, 3 LOST
//   mine_hit       out  1            one-cycle pulse on the cycle LOST is entered
// BEHAVIOUR
// - Reset (rst=0, async) and new_game=1: every output 0, game_state=IDLE.
//   new_game has priority over all other inputs in that cycle.
// - Valid commands: flag/reveal are ignored when tile_index >= TOTAL_TILES and in
//   states WON and LOST.
// - flag and reveal in the same cycle: flag wins; reveal is dropped.
// - Flag toggle:
//   - Ignored if the tile is revealed.
//   - Setting a flag is ignored when flag_count == NUM_MINES; clearing is always allowed.
//   - flag_count changes by +/-1 in the same cycle as the flagged bit.
// - Reveal:
//   - Ignored if the tile is flagged.
//   - Otherwise the revealed bit is set next edge.
//   - IDLE->PLAY on the first accepted reveal.
//   - Revealing an already-revealed tile is a no-op (no mine check).
// - Flood: when flood_apply=1 in IDLE or PLAY, revealed |= flood_update & ~flagged.
//   Merges with a single reveal in the same cycle.
// - Mine hit: an accepted reveal where mine_map[tile_index]=1 causes the following,
//   all at the next edge:
//   - revealed bit set, game_state=LOST, mine_hit=1 for 1 cycle;
//   - revealed |= mine_map (all mines shown in the same edge);
//   - any flood_apply that cycle still merges.
// - revealed_count: registered popcount of revealed, one cycle behind revealed.
// - Win: in PLAY, when revealed_count == TOTAL_TILES-NUM_MINES and no mine bit is
//   revealed, game_state=WON next edge.
//   - Net latency is 2 cycles after the final revealing edge.
//   - LOST takes priority over WON if both hold.
// - WON and LOST are sticky until new_game or rst. Flood is ignored there.
// - Widths: counters saturate-free by construction (bounded by TOTAL_TILES).
//   tile_index compare uses full INDEX_BITS width.
// TESTING
// - rst low mid-game with bits set -> all outputs 0 immediately (async), IDLE after release.
// - 8x8, NUM_MINES=10: flag idx 5 twice -> flagged[5] 1 then 0; flag_count 1 then 0.
// - Flag 10 distinct tiles, then flag idx 20 -> flagged[20]=0, flag_count stays 10.
//   Unflag idx 5 -> 9.
// - Reveal idx 3 (no mine) in IDLE -> revealed[3]=1, state PLAY.
//   reveal+flag same cycle idx 7 -> flagged[7]=1, revealed[7]=0.
// - Mine at idx 9, reveal 9 -> state=3, mine_hit pulses 1 cycle, revealed==orig|mine_map.
//   Further flag/reveal ignored.
// - flood_apply mask 0xFFFF with flagged[2]=1 -> revealed[2] stays 0.
//   Revealing all 54 safe tiles -> WON 2 cycles later; new_game -> all 0, IDLE.

Source files
------------

// File: rtl/tile_state_mgr.sv
// Per-tile flag/reveal store for the minesweeper core with flag budget,
// mine-hit handling, win detection and the game state machine.
module tile_state_mgr #(
  parameter int GRID_W    = 8,
  parameter int GRID_H    = 8,
  parameter int NUM_MINES = 10,
  localparam int TOTAL_TILES = GRID_W * GRID_H,
  localparam int INDEX_BITS  = $clog2(TOTAL_TILES),
  localparam int CNT_BITS    = $clog2(TOTAL_TILES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_game,
  input  logic [INDEX_BITS-1:0]  tile_index,
  input  logic                   flag,
  input  logic                   reveal,
  input  logic [TOTAL_TILES-1:0] mine_map,
  input  logic [TOTAL_TILES-1:0] flood_update,
  input  logic                   flood_apply,
  output logic [TOTAL_TILES-1:0] flagged,
  output logic [TOTAL_TILES-1:0] revealed,
  output logic [CNT_BITS-1:0]    flag_count,
  output logic [CNT_BITS-1:0]    revealed_count,
  output logic [1:0]             game_state,
  output logic                   mine_hit
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WON  = 2'd2,
    S_LOST = 2'd3
  } state_t;

  localparam logic [INDEX_BITS:0] TILE_LIMIT  = (INDEX_BITS+1)'(TOTAL_TILES);
  localparam logic [CNT_BITS-1:0] FLAG_BUDGET = CNT_BITS'(NUM_MINES);
  localparam logic [CNT_BITS-1:0] SAFE_TILES  = CNT_BITS'(TOTAL_TILES - NUM_MINES);
  localparam logic [CNT_BITS-1:0] CNT_ONE     = CNT_BITS'(1);

  state_t                 state_q, state_d;
  logic [TOTAL_TILES-1:0] flagged_q, flagged_d;
  logic [TOTAL_TILES-1:0] revealed_q, revealed_d;
  logic [CNT_BITS-1:0]    flag_count_q, flag_count_d;
  logic [CNT_BITS-1:0]    revealed_count_q, revealed_count_d;
  logic                   mine_hit_q, mine_hit_d;

  logic                   active;
  logic                   cmd_ok;
  logic                   flag_acc;
  logic                   reveal_acc;
  logic                   hit_now;
  logic [TOTAL_TILES-1:0] flood_mask;
  logic [CNT_BITS-1:0]    reveal_pop;

  assign active = (state_q == S_IDLE) || (state_q == S_PLAY);
  assign cmd_ok = active && ({1'b0, tile_index} < TILE_LIMIT);

  // Clearing a flag is always allowed; setting one needs budget left.
  assign flag_acc = flag && cmd_ok && !revealed_q[tile_index] &&
                    (flagged_q[tile_index] || (flag_count_q != FLAG_BUDGET));

  // A simultaneous flag request always drops the reveal.
  assign reveal_acc = reveal && !flag && cmd_ok &&
                      !flagged_q[tile_index] && !revealed_q[tile_index];
  assign hit_now    = reveal_acc && mine_map[tile_index];

  generate
    for (genvar gi = 0; gi < TOTAL_TILES; gi++) begin : g_flood
      assign flood_mask[gi] = flood_apply & active & flood_update[gi] & ~flagged_q[gi];
    end
  endgenerate

  always_comb begin
    reveal_pop = '0;
    for (int i = 0; i < TOTAL_TILES; i++) begin
      reveal_pop = reveal_pop + CNT_BITS'(revealed_q[i]);
    end
  end

  always_comb begin
    flagged_d        = flagged_q;
    revealed_d       = revealed_q;
    flag_count_d     = flag_count_q;
    revealed_count_d = reveal_pop;
    state_d          = state_q;
    mine_hit_d       = 1'b0;

    if (new_game) begin
      flagged_d        = '0;
      revealed_d       = '0;
      flag_count_d     = '0;
      revealed_count_d = '0;
      state_d          = S_IDLE;
    end else begin
      if (flag_acc) begin
        flagged_d[tile_index] = ~flagged_q[tile_index];
        flag_count_d = flagged_q[tile_index] ? (flag_count_q - CNT_ONE)
                                             : (flag_count_q + CNT_ONE);
      end

      revealed_d = revealed_d | flood_mask;

      if (reveal_acc) begin
        revealed_d[tile_index] = 1'b1;
        if (state_q == S_IDLE) begin
          state_d = S_PLAY;
        end
      end

      // Loss exposes every mine on the same edge and outranks a win.
      if (hit_now) begin
        revealed_d = revealed_d | mine_map;
        state_d    = S_LOST;
        mine_hit_d = 1'b1;
      end else if ((state_q == S_PLAY) && (revealed_count_q == SAFE_TILES) &&
                   ((revealed_q & mine_map) == '0)) begin
        state_d = S_WON;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      flagged_q        <= '0;
      revealed_q       <= '0;
      flag_count_q     <= '0;
      revealed_count_q <= '0;
      mine_hit_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      flagged_q        <= flagged_d;
      revealed_q       <= revealed_d;
      flag_count_q     <= flag_count_d;
      revealed_count_q <= revealed_count_d;
      mine_hit_q       <= mine_hit_d;
    end
  end

  assign flagged        = flagged_q;
  assign revealed       = revealed_q;
  assign flag_count     = flag_count_q;
  assign revealed_count = revealed_count_q;
  assign game_state     = state_q;
  assign mine_hit       = mine_hit_q;

endmodule

// File: tb/tb_tile_state_mgr.sv
// Scoreboard bench for tile_state_mgr: the driver queues hand-computed expected
// outputs per cycle, and a negedge monitor pops and compares them.
module tb_tile_state_mgr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        new_game = 1'b0;
  logic [5:0]  tile_index = '0;
  logic        flag = 1'b0;
  logic        reveal = 1'b0;
  logic [63:0] mine_map = '0;
  logic [63:0] flood_update = '0;
  logic        flood_apply = 1'b0;
  logic [63:0] flagged;
  logic [63:0] revealed;
  logic [6:0]  flag_count;
  logic [6:0]  revealed_count;
  logic [1:0]  game_state;
  logic        mine_hit;

  tile_state_mgr #(.GRID_W(8), .GRID_H(8), .NUM_MINES(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .new_game       (new_game),
    .tile_index     (tile_index),
    .flag           (flag),
    .reveal         (reveal),
    .mine_map       (mine_map),
    .flood_update   (flood_update),
    .flood_apply    (flood_apply),
    .flagged        (flagged),
    .revealed       (revealed),
    .flag_count     (flag_count),
    .revealed_count (revealed_count),
    .game_state     (game_state),
    .mine_hit       (mine_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       nm;
    logic [63:0] flg;
    logic [63:0] rev;
    logic [6:0]  fc;
    logic [6:0]  rc;
    logic [1:0]  st;
    logic        hit;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [63:0] e_flg, e_rev;
  logic [6:0]  e_fc, e_rc;
  logic [1:0]  e_st;
  logic        e_hit;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%h expected=%h", nm, fld, got, exp);
    end
  endtask

  task automatic check_item(input exp_t e);
    chk(e.nm, "flagged", flagged, e.flg);
    chk(e.nm, "revealed", revealed, e.rev);
    chk(e.nm, "flag_count", 64'(flag_count), 64'(e.fc));
    chk(e.nm, "revealed_count", 64'(revealed_count), 64'(e.rc));
    chk(e.nm, "game_state", 64'(game_state), 64'(e.st));
    chk(e.nm, "mine_hit", 64'(mine_hit), 64'(e.hit));
    $display("txn %-20s st=%0d fc=%0d rc=%0d hit=%0b rev=%h flg=%h",
             e.nm, game_state, flag_count, revealed_count, mine_hit, revealed, flagged);
  endtask

  function automatic exp_t snap(input string nm, input int at);
    exp_t e;
    e.cyc = at; e.nm = nm; e.flg = e_flg; e.rev = e_rev;
    e.fc = e_fc; e.rc = e_rc; e.st = e_st; e.hit = e_hit;
    return e;
  endfunction

  // Monitor: compare each queued expectation on the negedge it falls due.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      check_item(e);
    end
  end

  // Apply one cycle of stimulus; expected outputs appear after the next posedge.
  task automatic step(input string nm, input logic f, input logic r, input int idx,
                      input logic fa, input logic [63:0] fu, input logic ng);
    flag = f; reveal = r; tile_index = 6'(idx);
    flood_apply = fa; flood_update = fu; new_game = ng;
    q.push_back(snap(nm, cyc + 1));
    @(negedge clk);
    flag = 1'b0; reveal = 1'b0; flood_apply = 1'b0; new_game = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    e_flg = '0; e_rev = '0; e_fc = '0; e_rc = '0; e_st = 2'd0; e_hit = 1'b0;
    mine_map = 64'hFF80_0000_0000_0200;  // mines at 9 and 55..63
    repeat (2) @(negedge clk);
    check_item(snap("reset", cyc));
    rst = 1'b1;

    e_flg[5] = 1'b1; e_fc = 7'd1; step("flag5_set", 1, 0, 5, 0, '0, 0);
    e_flg[5] = 1'b0; e_fc = 7'd0; step("flag5_clr", 1, 0, 5, 0, '0, 0);
    e_flg[5] = 1'b1; e_fc = 7'd1; step("budget_5", 1, 0, 5, 0, '0, 0);
    for (int t = 10; t <= 18; t++) begin
      e_flg[t] = 1'b1; e_fc = e_fc + 7'd1;
      step("budget_fill", 1, 0, t, 0, '0, 0);
    end
    step("flag_over_budget", 1, 0, 20, 0, '0, 0);
    e_flg[5] = 1'b0; e_fc = 7'd9; step("unflag5", 1, 0, 5, 0, '0, 0);
    e_rev = 64'h8; e_st = 2'd1; step("reveal3", 0, 1, 3, 0, '0, 0);
    e_flg[7] = 1'b1; e_fc = 7'd10; e_rc = 7'd1;
    step("flag_beats_reveal", 1, 1, 7, 0, '0, 0);
    e_rev = 64'hFF80_0000_0000_0208; e_st = 2'd3; e_hit = 1'b1;
    step("mine_hit9", 0, 1, 9, 0, '0, 0);
    e_hit = 1'b0; e_rc = 7'd11; step("lost_flag", 1, 0, 20, 0, '0, 0);
    step("lost_reveal", 0, 1, 21, 0, '0, 0);
    step("lost_flood", 0, 0, 0, 1, '1, 0);

    #2 rst = 1'b0;
    #1;
    e_flg = '0; e_rev = '0; e_fc = '0; e_rc = '0; e_st = 2'd0; e_hit = 1'b0;
    check_item(snap("async_rst", cyc));
    @(negedge clk);
    rst = 1'b1;
    step("post_rst_idle", 0, 0, 0, 0, '0, 0);

    mine_map = 64'hFFC0_0000_0000_0000;  // mines at 54..63
    e_flg[2] = 1'b1; e_fc = 7'd1; step("g2_flag2", 1, 0, 2, 0, '0, 0);
    e_rev = 64'hFFFB; step("flood_skips_flag", 0, 0, 0, 1, 64'hFFFF, 0);
    e_rc = 7'd15; step("count_lag", 0, 0, 0, 0, '0, 0);
    e_flg = '0; e_fc = 7'd0; step("unflag2", 1, 0, 2, 0, '0, 0);
    e_rev = 64'hFFFF; e_st = 2'd1; step("reveal2", 0, 1, 2, 0, '0, 0);
    e_rev = 64'h003F_FFFF_FFFF_FFFF; e_rc = 7'd16;
    step("flood_plus_reveal", 0, 1, 53, 1, 64'h001F_FFFF_FFFF_0000, 0);
    e_rc = 7'd54; step("win_wait1", 0, 0, 0, 0, '0, 0);
    e_st = 2'd2; step("win", 0, 0, 0, 0, '0, 0);
    step("won_reveal_mine", 0, 1, 60, 0, '0, 0);
    step("won_flag", 1, 0, 0, 0, '0, 0);
    step("won_flood", 0, 0, 0, 1, '1, 0);
    e_flg = '0; e_rev = '0; e_fc = '0; e_rc = '0; e_st = 2'd0;
    step("new_game", 1, 1, 4, 1, '1, 1);
    step("after_new_game", 0, 0, 0, 0, '0, 0);

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
